div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start_i  input  1  divide request from EX; held high until ready_o is seen.
REQ-004 SHALL have port: annul_i  input  1  abort the current divide (flush or exception).
REQ-005 SHALL have port: signed_div_i  input  1  1 = DIV, 0 = DIVU.
REQ-006 SHALL have port: opdata1_i  input  32  dividend.
REQ-007 SHALL have port: opdata2_i  input  32  divisor.
REQ-008 SHALL have port: result_o  output  64  {remainder[63:32], quotient[31:0]} for HI/LO.
REQ-009 SHALL have port: ready_o  output  1  result_o valid.
REQ-010 SHALL have port: stallreq_o  output  1  EX stall request to the pipeline controller.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BYZERO, ON, END; all state and outputs registered except stallreq_o.
REQ-012 SHALL drive stallreq_o = start_i & ~ready_o (combinational).
REQ-013 FREE: with start_i=1 and annul_i=0, SHALL latch |opdata1_i| and |opdata2_i| (absolute values if signed_div_i=1, raw values otherwise), latch the operand signs, clear cnt, and go to ON; otherwise SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-014 ON: SHALL perform one restoring step per cycle while cnt<32: shift the 65-bit {rem,quot} working register left by 1; trial = rem[32:0] - {1'b0,divisor}; if non-negative, rem=trial and quot LSB=1; cnt increments.
REQ-015 ON with cnt==32: SHALL apply the sign fix-up (signed only: negate quotient if the operand signs differ; give remainder the dividend's sign), load result_o, set ready_o=1, and go to END.
REQ-016 Latency SHALL be: start sampled at edge 0, iterations at edges 1-32, ready_o=1 after edge 33.
REQ-017 END: SHALL hold result_o and ready_o=1 while start_i=1; when start_i=0, SHALL go to FREE with ready_o=0 and result_o=0 on the next edge.
REQ-018 annul_i=1 in ON or BYZERO SHALL go to FREE on the next edge with ready_o=0, result_o=0, cnt=0; annul_i in END SHALL act like start_i=0.
REQ-019 annul_i=1 and start_i=1 together in FREE SHALL NOT start a divide.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 (32-bit wrap) and remainder 0, with no flag.
REQ-021 Operand changes after the start edge SHALL NOT affect the result.

Reset
REQ-022 rst=1 SHALL force state=FREE, cnt=0, ready_o=0, result_o=0, regardless of state (including mid-divide).
REQ-023 rst SHALL take priority over start_i and annul_i.

Configuration
REQ-024 Macro DIV_ZERO_DETECT_EN SHALL select the divide-by-zero handling.
REQ-025 Defined: FREE with start_i=1 and opdata2_i=0 SHALL go to BYZERO; BYZERO SHALL go to END on the next edge with result_o=0 and ready_o=1, so ready_o is high after edge 1.
REQ-026 Not defined: the BYZERO state SHALL be absent, and a zero divisor SHALL take the normal 33-edge path. The unsigned result SHALL be quotient 0xFFFFFFFF and remainder opdata1_i. In signed mode, REQ-015 fix-up SHALL be applied to quotient 0xFFFFFFFF and remainder |opdata1_i|.

Verification
REQ-027 Unsigned 100/7: start held -> ready_o=1 after edge 33, result_o={32'd2, 32'd14}, stallreq_o falls in the same cycle.
REQ-028 Signed -7/2: quotient 0xFFFFFFFD and remainder 0xFFFFFFFF. Signed 7/-2: quotient 0xFFFFFFFD and remainder 0x00000001.
REQ-029 Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000 and remainder 0x00000000 after edge 33.
REQ-030 Divide 5/0: with DIV_ZERO_DETECT_EN, ready_o=1 after edge 1 and result 0. Without it, ready_o=1 after edge 33 with result {0x00000005, 0xFFFFFFFF}.
REQ-031 Annul at edge 10 of 100/7 -> FREE, ready_o=0, result_o=0 at edge 11. A new 9/3 start then gives {0, 3} 33 edges later.
REQ-032 rst asserted at edge 20 of a divide -> all outputs 0 and FSM in FREE at the next edge. A subsequent divide completes normally.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- 32-bit iterative restoring divider for the EX stage (DIV / DIVU).
// Produces {remainder, quotient} for HI/LO after 33 clock edges.
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined     : a zero divisor short-cuts through BYZERO and returns 0 after
//                 one edge.
//   not defined : a zero divisor runs the normal iterative path, which yields
//                 quotient all-ones and remainder equal to the dividend.
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
`ifdef DIV_ZERO_DETECT_EN
        S_BYZERO = 2'd1,
`endif
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;        // {rem[32:0], quot[31:0]}
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [64:0] shifted_s;
    logic [33:0] trial_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    // Magnitude of a 32-bit operand; 0x80000000 wraps to itself, which still
    // reads correctly as an unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negate when requested (sign fix-up of the result).
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FREE;
            cnt_q      <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state, restoring iteration step and sign fix-up.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        shifted_s  = work_q << 1;
        trial_s    = {1'b0, shifted_s[64:32]} - {2'b00, divisor_q};
        quot_fix_s = neg_if(work_q[31:0], neg_quot_q);
        rem_fix_s  = neg_if(work_q[63:32], neg_rem_q);

        case (state_q)
            S_FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    work_d     = {33'd0, abs32(opdata1_i, signed_div_i)};
                    divisor_d  = abs32(opdata2_i, signed_div_i);
                    neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d  = signed_div_i & opdata1_i[31];
                    cnt_d      = 6'd0;
`ifdef DIV_ZERO_DETECT_EN
                    if (opdata2_i == 32'd0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                    end
`else
                    state_d    = S_ON;
`endif
                end else begin
                    state_d = S_FREE;
                end
            end
`ifdef DIV_ZERO_DETECT_EN
            S_BYZERO: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = S_END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
`endif
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else if (cnt_q != 6'd32) begin
                    // Keep the trial difference only when it did not borrow.
                    if (!trial_s[33]) begin
                        work_d = {trial_s[32:0], shifted_s[31:0]} | 65'd1;
                    end else begin
                        work_d = shifted_s;
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix_s, quot_fix_s};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end
            S_END: begin
                if (!start_i || annul_i) begin
                    state_d  = S_FREE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    state_d = S_END;
                end
            end
            default: begin
                state_d  = S_FREE;
                cnt_d    = 6'd0;
                result_d = 64'd0;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed, table-driven self-checking bench for div_unit.
// Honours DIV_ZERO_DETECT_EN for the divide-by-zero expectation.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start a divide at the current negedge, scramble operands after the start
    // edge, wait for ready, check hold in END, then leave END.
    task automatic run_div(input vec_t v, input bit exit_by_annul, input int idx);
        int  lat;
        bit  done;
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        #1;
        chk($sformatf("v%0d stall_req_start", idx), {63'd0, stallreq_o}, 64'd1);
        @(posedge clk);
        #1;
        opdata1_i    = ~v.a;
        opdata2_i    = v.b + 32'd3;
        signed_div_i = ~v.sgn;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_o) done = 1'b1;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d result", idx), result_o, v.exp);
        chk($sformatf("v%0d stall_drop", idx), {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d end_hold", idx), result_o, v.exp);
        chk($sformatf("v%0d end_ready", idx), {63'd0, ready_o}, 64'd1);
        if (exit_by_annul) annul_i = 1'b1;
        else               start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d exit_ready", idx), {63'd0, ready_o}, 64'd0);
        chk($sformatf("v%0d exit_result", idx), result_o, 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    // Begin a 100/7 unsigned divide at the current negedge and run edges 0..n-1.
    task automatic begin_partial(input int n);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t v93;
        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},  33};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000},  33};
`ifdef DIV_ZERO_DETECT_EN
        vecs[4] = '{1'b0, 32'd5,          32'd0,        64'd0,                         1};
`else
        vecs[4] = '{1'b0, 32'd5,          32'd0,        {32'h00000005, 32'hFFFFFFFF},  33};
`endif
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h00000000, 32'hFFFFFFFF},  33};
        vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E},  33};
        vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,        {32'h00000001, 32'h7FFFFFFC},  33};
        vecs[8] = '{1'b0, 32'd9,          32'd3,        {32'd0,        32'd3},         33};
        vecs[9] = '{1'b1, 32'd12345,      32'd100,      {32'd45,       32'd123},       33};
        v93 = vecs[8];

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",  {63'd0, ready_o},    64'd0);
        chk("reset_result", result_o,            64'd0);
        chk("reset_stall",  {63'd0, stallreq_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i], (i % 3) == 2, i);
        end

        // Annul sampled at edge 10 of 100/7, then 9/3 must run from FREE.
        begin_partial(10);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("annul_ready",  {63'd0, ready_o},    64'd0);
        chk("annul_result", result_o,            64'd0);
        chk("annul_stall",  {63'd0, stallreq_o}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
        run_div(v93, 1'b0, 100);

        // start together with annul in FREE must not launch a divide.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("start_annul_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
        run_div(v93, 1'b0, 101);

        // Reset sampled at edge 20 of a divide.
        begin_partial(20);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready",  {63'd0, ready_o}, 64'd0);
        chk("midrst_result", result_o,         64'd0);
        rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        run_div(v93, 1'b0, 102);

        // Reset while parked in END with a non-zero result.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("endrst_pre_result", result_o, {32'd2, 32'd14});
        rst = 1'b1; annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("endrst_ready",  {63'd0, ready_o}, 64'd0);
        chk("endrst_result", result_o,         64'd0);
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
